// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
//   Serial consumer of radix-4 Booth partial products for 11x11 signed
//   multiplication. Six 12-bit partial products (already bit-inverted when
//   negative) plus six negate/carry bits are latched on accept. They are then
//   sign-extended, shifted by 2*i and summed one term per cycle into a 22-bit
//   signed product. There is a valid/ready handshake on both sides.
//
//   Optional build macro: BOOTH_ZERO_SKIP_EN
//     When defined, terms with pp_i==0 and neg[i]==0 are skipped, so the
//     accumulate phase lasts max(1, nonzero-term count) cycles. The result is
//     identical to the default build, where all six terms are always added.

module booth_pp_accumulator #(
  parameter int N_PP = 6,
  parameter int PP_W = 12,
  parameter int P_W  = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_PP*PP_W-1:0] pp_bus,
  input  logic [N_PP-1:0]      neg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_W-1:0]       product
);

  localparam int IDX_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [P_W-1:0]       acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [P_W-1:0]       product_q, product_d;
  logic                 out_valid_q, out_valid_d;
  logic [N_PP*PP_W-1:0] pp_q, pp_d;
  logic [N_PP-1:0]      neg_q, neg_d;

  logic                 accept;
  logic [IDX_W-1:0]     sel_idx;
  logic                 last_term;
  logic                 add_en;
  logic [PP_W-1:0]      cur_pp;
  logic                 cur_neg;
  logic [P_W-1:0]       term_base;
  logic [P_W-1:0]       term;
  logic [P_W-1:0]       acc_sum;

`ifdef BOOTH_ZERO_SKIP_EN
  logic [N_PP-1:0]      pend_q, pend_d;
  logic [N_PP-1:0]      pend_rem;
  logic [N_PP-1:0]      in_nonzero;
  logic [IDX_W-1:0]     low_idx;
  logic [IDX_W-1:0]     next_idx;
  logic                 pend_any;
`endif

  // Upstream may hand over a new operation when idle, or in the same cycle the finished result leaves
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign product   = product_q;

`ifdef BOOTH_ZERO_SKIP_EN
  // Locate the lowest pending nonzero term and the one after it, and flag the final term
  always_comb begin
    in_nonzero = '0;
    low_idx    = '0;
    next_idx   = '0;
    pend_any   = |pend_q;
    for (int i = 0; i < N_PP; i++) begin
      in_nonzero[i] = (|pp_bus[PP_W*i +: PP_W]) | neg[i];
    end
    for (int i = N_PP - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        low_idx = IDX_W'(i);
      end
    end
    pend_rem = pend_q & ~(N_PP'(1) << low_idx);
    for (int i = N_PP - 1; i >= 0; i--) begin
      if (pend_rem[i]) begin
        next_idx = IDX_W'(i);
      end
    end
    sel_idx   = pend_any ? low_idx : idx_q;
    last_term = ~|pend_rem;
    add_en    = pend_any;
  end
`else
  // Every window is visited in order; the sixth one closes the operation
  always_comb begin
    sel_idx   = idx_q;
    last_term = (idx_q == IDX_W'(N_PP - 1));
    add_en    = 1'b1;
  end
`endif

  // Select the current term, sign-extend it, fold in its carry bit and align it to its window
  always_comb begin
    cur_pp  = '0;
    cur_neg = 1'b0;
    for (int i = 0; i < N_PP; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        cur_pp  = pp_q[PP_W*i +: PP_W];
        cur_neg = neg_q[i];
      end
    end
    term_base = {{(P_W-PP_W){cur_pp[PP_W-1]}}, cur_pp} + {{(P_W-1){1'b0}}, cur_neg};
    term      = add_en ? (term_base << {sel_idx, 1'b0}) : '0;
    acc_sum   = acc_q + term;
  end

  // Next-state logic: IDLE -> ACCUM -> DONE, with back-to-back restart from DONE
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    pp_d        = pp_q;
    neg_d       = neg_q;
`ifdef BOOTH_ZERO_SKIP_EN
    pend_d      = pend_q;
`endif

    case (state_q)
      ST_ACCUM: begin
        acc_d = acc_sum;
`ifdef BOOTH_ZERO_SKIP_EN
        pend_d = pend_rem;
        idx_d  = next_idx;
`else
        idx_d  = idx_q + IDX_W'(1);
`endif
        if (last_term) begin
          product_d   = acc_sum;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      pp_d        = pp_bus;
      neg_d       = neg;
      acc_d       = '0;
      idx_d       = '0;
      out_valid_d = 1'b0;
      state_d     = ST_ACCUM;
`ifdef BOOTH_ZERO_SKIP_EN
      pend_d      = in_nonzero;
`endif
    end
  end

  // State registers; reset abandons any operation in flight without producing output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      pp_q        <= '0;
      neg_q       <= '0;
`ifdef BOOTH_ZERO_SKIP_EN
      pend_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      pp_q        <= pp_d;
      neg_q       <= neg_d;
`ifdef BOOTH_ZERO_SKIP_EN
      pend_q      <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Testbench for booth_pp_accumulator.
// A small radix-4 Booth encoder model turns (A, X) into partial products.
// The expected product A*X is pushed to a scoreboard queue when an operation
// is accepted, and it is popped and compared when the result appears.

module tb_booth_pp_accumulator;

   localparam int N_PP = 6;
   localparam int PP_W = 12;
   localparam int P_W  = 22;

   logic                  clock = 1'b0;
   logic                  reset;
   logic                  inValid;
   logic                  inReady;
   logic [N_PP*PP_W-1:0]  ppBus;
   logic [N_PP-1:0]       negBits;
   logic                  outValid;
   logic                  outReady;
   logic [P_W-1:0]        product;

   int                    nChecks = 0;
   int                    nFail   = 0;
   logic signed [P_W-1:0] scoreboard[$];

   booth_pp_accumulator #(.N_PP(N_PP), .PP_W(PP_W), .P_W(P_W)) dut (
      .clk       (clock),
      .rst       (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .pp_bus    (ppBus),
      .neg       (negBits),
      .out_valid (outValid),
      .out_ready (outReady),
      .product   (product)
   );

   // Free-running clock, period 10
   always #5 clock = ~clock;

   // Advance one cycle and settle just after the rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Radix-4 Booth encoding of multiplier x applied to multiplicand a
   task automatic encode(input int a, input int x, output logic [N_PP*PP_W-1:0] pb,
                         output logic [N_PP-1:0] ng);
      logic [11:0] a12;
      logic [12:0] xe;
      logic [2:0]  win;
      int          d;
      a12 = 12'(a);
      xe  = {1'(x >>> 10), 11'(x), 1'b0};
      pb  = '0;
      ng  = '0;
      for (int i = 0; i < N_PP; i++) begin
         win = xe[2*i +: 3];
         d   = -2 * int'(win[2]) + int'(win[1]) + int'(win[0]);
         case (d)
            1:  pb[PP_W*i +: PP_W] = a12;
            2:  pb[PP_W*i +: PP_W] = a12 << 1;
            -1: begin pb[PP_W*i +: PP_W] = ~a12;        ng[i] = 1'b1; end
            -2: begin pb[PP_W*i +: PP_W] = ~(a12 << 1); ng[i] = 1'b1; end
            default: pb[PP_W*i +: PP_W] = '0;
         endcase
      end
   endtask

   // Cycles from accept to out_valid expected for this operation
   task automatic expectedLatency(input int a, input int x, output int lat);
      logic [N_PP*PP_W-1:0] pb;
      logic [N_PP-1:0]      ng;
      int                   nz;
      encode(a, x, pb, ng);
      nz = 0;
      for (int i = 0; i < N_PP; i++) begin
         if ((pb[PP_W*i +: PP_W] != '0) || ng[i]) nz++;
      end
`ifdef BOOTH_ZERO_SKIP_EN
      lat = (nz == 0) ? 1 : nz;
`else
      lat = 6;
`endif
   endtask

   // Present one operation, wait (bounded) for acceptance, record its expected result
   task automatic applyStimulus(input int a, input int x);
      logic [N_PP*PP_W-1:0] pb;
      logic [N_PP-1:0]      ng;
      bit                   ok;
      encode(a, x, pb, ng);
      ppBus   = pb;
      negBits = ng;
      inValid = 1'b1;
      ok      = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (inReady) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok) begin
         scoreboard.push_back(P_W'(a * x));
         tick();
      end else begin
         nChecks++;
         nFail++;
         $display("[TB] FAIL accept_timeout a=%0d x=%0d in_ready=%b required 1", a, x, inReady);
      end
      inValid = 1'b0;
      ppBus   = {$urandom, $urandom, $urandom};
      negBits = 6'($urandom);
   endtask

   // Wait (bounded) for out_valid; returns the number of cycles waited
   task automatic waitOutput(output int cyc);
      cyc = 0;
      while (!outValid && cyc < 64) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b1;
      ppBus    = '0;
      negBits  = '0;
      tick();
      tick();
      nChecks++;
      if (outValid !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL reset_out_valid got %b required 0", outValid);
      end
      nChecks++;
      if (product !== '0) begin
         nFail++;
         $display("[TB] FAIL reset_product got %h required 0", product);
      end
      reset = 1'b0;
      tick();
      nChecks++;
      if (inReady !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL reset_in_ready got %b required 1", inReady);
      end
   endtask

   // Run one op with out_ready high and check result and latency
   task automatic test_single(input string name, input int a, input int x);
      int                    cyc;
      int                    lat;
      logic signed [P_W-1:0] exp;
      expectedLatency(a, x, lat);
      applyStimulus(a, x);
      waitOutput(cyc);
      nChecks++;
      if (cyc !== lat) begin
         nFail++;
         $display("[TB] FAIL %s_latency got %0d required %0d", name, cyc, lat);
      end
      if (scoreboard.size() > 0) begin
         exp = scoreboard.pop_front();
         nChecks++;
         if (product !== exp || outValid !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL %s_product got %0d (valid %b) required %0d", name,
                     $signed(product), outValid, exp);
         end
      end
      nChecks++;
      if (inReady !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL %s_in_ready got %b required 1", name, inReady);
      end
      tick();
      nChecks++;
      if (outValid !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL %s_out_valid_drop got %b required 0", name, outValid);
      end
   endtask

   // Hold the result under backpressure, then restart back-to-back on release
   task automatic test_back_to_back();
      int                    cyc;
      logic signed [P_W-1:0] exp;
      logic [N_PP*PP_W-1:0]  pb;
      logic [N_PP-1:0]       ng;
      outReady = 1'b0;
      applyStimulus(123, -456);
      waitOutput(cyc);
      exp = (scoreboard.size() > 0) ? scoreboard.pop_front() : '0;
      for (int k = 0; k < 10; k++) begin
         nChecks++;
         if (outValid !== 1'b1 || product !== exp || inReady !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL hold_cycle%0d valid=%b product=%0d in_ready=%b required 1/%0d/0",
                     k, outValid, $signed(product), inReady, exp);
         end
         tick();
      end
      encode(-77, 300, pb, ng);
      ppBus    = pb;
      negBits  = ng;
      inValid  = 1'b1;
      outReady = 1'b1;
      #1;
      nChecks++;
      if (inReady !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL b2b_in_ready got %b required 1", inReady);
      end
      scoreboard.push_back(P_W'(-77 * 300));
      tick();
      inValid = 1'b0;
      ppBus   = '1;
      nChecks++;
      if (outValid !== 1'b0 || inReady !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL b2b_started valid=%b in_ready=%b required 0/0", outValid, inReady);
      end
      waitOutput(cyc);
      exp = (scoreboard.size() > 0) ? scoreboard.pop_front() : '0;
      nChecks++;
      if (outValid !== 1'b1 || product !== exp) begin
         nFail++;
         $display("[TB] FAIL b2b_second got %0d (valid %b) required %0d", $signed(product), outValid, exp);
      end
      tick();
   endtask

   // Junk offered while busy must be ignored
   task automatic test_busy_ignore();
      int                    cyc;
      logic signed [P_W-1:0] exp;
      applyStimulus(-300, -683);
      tick();
      tick();
      nChecks++;
      if (inReady !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL busy_in_ready got %b required 0", inReady);
      end
      inValid = 1'b1;
      ppBus   = {$urandom, $urandom, $urandom};
      negBits = 6'h3F;
      tick();
      inValid = 1'b0;
      waitOutput(cyc);
      exp = (scoreboard.size() > 0) ? scoreboard.pop_front() : '0;
      nChecks++;
      if (outValid !== 1'b1 || product !== exp) begin
         nFail++;
         $display("[TB] FAIL busy_ignore got %0d (valid %b) required %0d", $signed(product), outValid, exp);
      end
      tick();
   endtask

   // Reset in the middle of accumulation aborts without output
   task automatic test_reset_midop();
      applyStimulus(100, -683);
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      void'(scoreboard.pop_back());
      nChecks++;
      if (outValid !== 1'b0 || product !== '0) begin
         nFail++;
         $display("[TB] FAIL midop_reset valid=%b product=%h required 0/0", outValid, product);
      end
      tick();
      reset = 1'b0;
      tick();
      nChecks++;
      if (inReady !== 1'b1 || outValid !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL midop_release in_ready=%b valid=%b required 1/0", inReady, outValid);
      end
      test_single("after_reset", 7, -2);
   endtask

   // Random operands checked against A*X
   task automatic test_random();
      int                    a;
      int                    x;
      int                    cyc;
      logic signed [P_W-1:0] exp;
      for (int n = 0; n < 1000; n++) begin
         a = int'($urandom_range(0, 2047)) - 1024;
         x = int'($urandom_range(0, 2047)) - 1024;
         applyStimulus(a, x);
         waitOutput(cyc);
         exp = (scoreboard.size() > 0) ? scoreboard.pop_front() : '0;
         nChecks++;
         if (outValid !== 1'b1 || product !== exp) begin
            nFail++;
            $display("[TB] FAIL random_%0d a=%0d x=%0d got %0d (valid %b) required %0d",
                     n, a, x, $signed(product), outValid, exp);
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single("a3_x5", 3, 5);
      test_single("min_min", -1024, -1024);
      test_single("max_min", 1023, -1024);
      test_back_to_back();
      test_busy_ignore();
      test_reset_midop();
      test_single("x_zero", 321, 0);
      test_single("x_one", -999, 1);
      test_single("a5_xm1", 5, -1);
      test_single("a_zero", 0, -683);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
